// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter (m0 = IFU, m1 = LSU) in front of a single memory port.
// One transaction in flight; protocol violations and response timeouts set a sticky err.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic                m0_gnt,
  output logic                m0_rsp_valid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_gnt,
  output logic                m1_rsp_valid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err,
  output logic [1:0]          dbg_state
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RSP = 2'd2} state_t;

  state_t          state;
  logic            owner;
  logic            last;
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  logic own_req;
  logic in_issue;
  logic in_wait;
  logic wd_hit;

  // Handshake: a requester holds req and payload until its gnt pulse (mem_req & mem_ready
  // in ISSUE); exactly one rsp_valid pulse later returns to the owner, mem_rsp_valid is
  // only legal in WAIT_RSP.
  assign own_req  = owner ? m1_req : m0_req;
  assign in_issue = (state == ISSUE);
  assign in_wait  = (state == WAIT_RSP);
  assign wd_hit   = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_rsp_valid) err_q <= 1'b1;
          if (m0_req || m1_req) begin
            // On contention the requester that was not served last wins.
            owner <= (m0_req && m1_req) ? ~last : m1_req;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rsp_valid) err_q <= 1'b1;
          if (!own_req) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else if (mem_ready) begin
            wd_cnt <= '0;
            state  <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            last  <= owner;
            state <= IDLE;
          end else if (wd_hit) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req   = in_issue & own_req;
  assign mem_we    = in_issue & owner & m1_we;
  assign mem_addr  = !in_issue ? '0 : (owner ? m1_addr : m0_addr);
  assign mem_wdata = (in_issue & owner) ? m1_wdata : '0;
  assign mem_wmask = (in_issue & owner) ? m1_wmask : '0;

  assign m0_gnt = in_issue & ~owner & m0_req & mem_ready;
  assign m1_gnt = in_issue &  owner & m1_req & mem_ready;

  assign m0_rsp_valid = in_wait & ~owner & mem_rsp_valid;
  assign m1_rsp_valid = in_wait &  owner & mem_rsp_valid;
  assign m0_rdata     = m0_rsp_valid ? mem_rdata : '0;
  assign m1_rdata     = m1_rsp_valid ? mem_rdata : '0;

  assign busy      = (state != IDLE);
  assign err       = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand sequences for
// contention, back-pressure, timeout, protocol violations and mid-transaction reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req, m1_req, m1_we, mem_ready, mem_rsp_valid;
  logic [31:0] m0_addr, m1_addr, m1_wdata, mem_rdata;
  logic [3:0]  m1_wmask;
  logic        m0_gnt, m0_rsp_valid, m1_gnt, m1_rsp_valid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_we, busy, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_gnt(m1_gnt), .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_addr = '0; m1_req = 0; m1_we = 0; m1_addr = '0;
    m1_wdata = '0; m1_wmask = '0; mem_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one record per clock cycle: inputs then outputs expected before the next posedge
  typedef struct {
    logic m0_req; logic [31:0] m0_addr;
    logic m1_req; logic m1_we; logic [31:0] m1_addr; logic [31:0] m1_wdata; logic [3:0] m1_wmask;
    logic rdy; logic rsv; logic [31:0] rdata;
    logic [1:0] gnt; logic [1:0] rsp; logic [31:0] r0; logic [31:0] r1;
    logic [5:0] ctl; logic [31:0] addr; logic [31:0] wdata; logic busy; logic err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // single fetch; idle m1 payload must not leak onto the memory pins
    vecs[0] = '{1, 32'h8000_0000, 0, 1, 32'h44, 32'h0, 4'hF, 1, 0, 32'h0,
                2'b00, 2'b00, 32'h0, 32'h0, 6'b00_0000, 32'h0, 32'h0, 0, 0};
    vecs[1] = '{1, 32'h8000_0000, 0, 1, 32'h44, 32'h0, 4'hF, 1, 0, 32'h0,
                2'b10, 2'b00, 32'h0, 32'h0, 6'b10_0000, 32'h8000_0000, 32'h0, 1, 0};
    vecs[2] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0010_0073,
                2'b00, 2'b10, 32'h0010_0073, 32'h0, 6'b00_0000, 32'h0, 32'h0, 1, 0};
    vecs[3] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0,
                2'b00, 2'b00, 32'h0, 32'h0, 6'b00_0000, 32'h0, 32'h0, 0, 0};
    // m1 store with one stall cycle; m0 address present but not requesting
    vecs[4] = '{0, 32'hFFFF_FFF0, 1, 1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0,
                2'b00, 2'b00, 32'h0, 32'h0, 6'b00_0000, 32'h0, 32'h0, 0, 0};
    vecs[5] = '{0, 32'hFFFF_FFF0, 1, 1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0,
                2'b00, 2'b00, 32'h0, 32'h0, 6'b11_1111, 32'h1000, 32'hDEAD_BEEF, 1, 0};
    vecs[6] = '{0, 32'hFFFF_FFF0, 1, 1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'h0,
                2'b01, 2'b00, 32'h0, 32'h0, 6'b11_1111, 32'h1000, 32'hDEAD_BEEF, 1, 0};
    vecs[7] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h1234_5678,
                2'b00, 2'b01, 32'h0, 32'h1234_5678, 6'b00_0000, 32'h0, 32'h0, 1, 0};
    // stray response in IDLE: ignored, err rises next cycle
    vecs[8] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'hAAAA_5555,
                2'b00, 2'b00, 32'h0, 32'h0, 6'b00_0000, 32'h0, 32'h0, 0, 0};
    vecs[9] = '{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0,
                2'b00, 2'b00, 32'h0, 32'h0, 6'b00_0000, 32'h0, 32'h0, 0, 1};

    clear_inputs();
    tick();
    #1;
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_outs", {m0_gnt, m1_gnt, m0_rsp_valid, m1_rsp_valid, mem_req}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      m0_req = vecs[i].m0_req; m0_addr = vecs[i].m0_addr;
      m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we; m1_addr = vecs[i].m1_addr;
      m1_wdata = vecs[i].m1_wdata; m1_wmask = vecs[i].m1_wmask;
      mem_ready = vecs[i].rdy; mem_rsp_valid = vecs[i].rsv; mem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_gnt", i), {m0_gnt, m1_gnt}, vecs[i].gnt);
      check($sformatf("v%0d_rsp", i), {m0_rsp_valid, m1_rsp_valid}, vecs[i].rsp);
      check($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].r0);
      check($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].r1);
      check($sformatf("v%0d_mem_ctl", i), {mem_req, mem_we, mem_wmask}, vecs[i].ctl);
      check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
      check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("v%0d_err", i), err, vecs[i].err);
      tick();
    end

    // contention: strict alternation starting with m0
    begin
      logic       rsp_next;
      logic [31:0] last_own;
      do_reset();
      exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
      m0_req = 1; m0_addr = 32'h8000_0100;
      m1_req = 1; m1_we = 1; m1_addr = 32'h3000; m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'hF;
      mem_ready = 1;
      rsp_next = 0; last_own = 0;
      for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
        mem_rsp_valid = rsp_next;
        mem_rdata = 32'hC0DE_0000 + 32'(cyc);
        #1;
        if (rsp_next) begin
          check("cont_rsp_route", {m0_rsp_valid, m1_rsp_valid}, (last_own == 0) ? 2'b10 : 2'b01);
          check("cont_rsp_rdata", (last_own == 0) ? m0_rdata : m1_rdata, mem_rdata);
        end
        if (m0_gnt || m1_gnt) begin
          check("cont_single_gnt", {m0_gnt, m1_gnt} == 2'b11, 0);
          last_own = m1_gnt ? 32'd1 : 32'd0;
          check("cont_grant_order", last_own, exp_q.pop_front());
          if (last_own == 1)
            check("cont_store_pins", {mem_we, mem_wmask, mem_addr, mem_wdata},
                  {1'b1, 4'hF, 32'h3000, 32'hDEAD_BEEF});
          rsp_next = 1;
        end else begin
          rsp_next = 0;
        end
        tick();
      end
      check("cont_grants_done", exp_q.size(), 0);
      check("cont_err", err, 0);
    end

    // back-pressure: five stalled ISSUE cycles
    do_reset();
    m1_req = 1; m1_addr = 32'h2000;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d_hold", i), {mem_req, mem_addr, m1_gnt}, {1'b1, 32'h2000, 1'b0});
      tick();
    end
    mem_ready = 1;
    #1;
    check("bp_gnt", {m1_gnt, mem_addr}, {1'b1, 32'h2000});
    tick();
    m1_req = 0; mem_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h5555_0001;
    #1;
    check("bp_rsp", {m1_rsp_valid, m1_rdata}, {1'b1, 32'h5555_0001});
    tick();
    mem_rsp_valid = 0;

    // watchdog with TIMEOUT=4: WAIT_RSP cycles wd_cnt=0..4, abort on the fifth
    do_reset();
    m0_req = 1; m0_addr = 32'h100; mem_ready = 1;
    tick();
    #1;
    check("to_gnt", m0_gnt, 1);
    tick();
    m0_req = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("to_wait%0d", i), {busy, err, m0_rsp_valid, m1_rsp_valid}, 4'b1000);
      tick();
    end
    #1;
    check("to_abort", {busy, err, m0_rsp_valid}, 3'b010);

    // m1 drops its request while in ISSUE
    do_reset();
    m1_req = 1; m1_addr = 32'h40;
    tick();
    m1_req = 0; mem_ready = 1;
    #1;
    check("drop_no_gnt", {m1_gnt, mem_req}, 2'b00);
    tick();
    #1;
    check("drop_abort", {busy, err}, 2'b01);

    // reset during WAIT_RSP, late response afterwards
    do_reset();
    m1_req = 1; m1_addr = 32'h80; mem_ready = 1;
    tick();
    #1;
    check("rst_pre_gnt", m1_gnt, 1);
    tick();
    m1_req = 0;
    #1;
    check("rst_pre_busy", busy, 1);
    rst_n = 0; mem_rsp_valid = 1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_outs", {m0_gnt, m1_gnt, m0_rsp_valid, m1_rsp_valid, mem_req}, 0);
    tick();
    rst_n = 1; m0_req = 1; m1_req = 1;
    tick();
    mem_rsp_valid = 0;
    #1;
    check("rst_m0_wins", {m0_gnt, m1_gnt}, 2'b10);
    check("rst_late_rsp_err", err, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
